// File: rtl/bist_pkg.sv
// Shared types for the BIST diagnostic fail log: FSM state encoding and
// the layout of one captured failure record.
package bist_pkg;

    localparam int PAT_W  = 3;
    localparam int SIZE   = 6;
    localparam int LENGTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOGGING = 2'd1,
        HOLD    = 2'd2
    } log_state_e;

    // Field order matches rd_entry, MSB first.
    typedef struct packed {
        logic [PAT_W-1:0]  pattern;
        logic [SIZE-1:0]   addr;
        logic [LENGTH-1:0] expected;
        logic [LENGTH-1:0] actual;
    } fail_entry_t;

endpackage

// File: rtl/fail_fifo.sv
// Show-ahead FIFO holding captured failure records. A clear empties it and
// may be combined with a push, which then lands in slot 0.
module fail_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_wr_idx;

    // Extra pointer MSB tells a full buffer apart from an empty one.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop    = pop && !empty && !clear;
    assign w_push   = push && (clear || !full || w_pop);
    assign w_wr_idx = clear ? '0 : r_wr_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? PTR_ONE : '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Storage is not reset, so an empty FIFO presents zeros instead.
    assign head = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/bist_fail_log.sv
// Diagnostic capture stage behind the MBIST top: logs failing compares into
// a small FIFO, counts failures and flags dropped records.
module bist_fail_log
    import bist_pkg::*;
#(
    parameter int SIZE   = 6,
    parameter int LENGTH = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       NbarT,
    input  logic                       fail,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [SIZE-1:0]            addr,
    input  logic [LENGTH-1:0]          expected,
    input  logic [LENGTH-1:0]          actual,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [PAT_W+2*LENGTH+SIZE-1:0] rd_entry,
    output logic [CNT_W-1:0]           fail_count,
    output logic                       overflow,
    output logic                       logging
);

    localparam int EW = PAT_W + 2*LENGTH + SIZE;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    log_state_e       r_state;
    logic             r_logging;
    logic [CNT_W-1:0] r_fail_count;
    logic             r_overflow;

    logic             w_clear;
    logic             w_qual;
    logic             w_pop_req;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [EW-1:0]    w_din;
    logic [EW-1:0]    w_head;

    // Entering LOGGING from IDLE or HOLD starts a fresh log.
    assign w_clear   = NbarT && (r_state != LOGGING);
    assign w_qual    = fail && NbarT;
    assign w_pop_req = rd_valid && rd_ready;
    assign w_drop    = w_qual && !w_clear && w_full && !w_pop_req;
    assign w_din     = {pattern, addr, expected, actual};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_logging <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (NbarT) begin
                        r_state   <= LOGGING;
                        r_logging <= 1'b1;
                    end
                end
                LOGGING: begin
                    if (!NbarT) begin
                        r_state   <= HOLD;
                        r_logging <= 1'b0;
                    end
                end
                HOLD: begin
                    if (NbarT) begin
                        r_state   <= LOGGING;
                        r_logging <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_logging <= 1'b0;
                end
            endcase
        end
    end

    // Counter includes dropped failures and sticks at its maximum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fail_count <= '0;
        end else if (w_clear) begin
            r_fail_count <= w_qual ? CNT_ONE : '0;
        end else if (w_qual && (r_fail_count != {CNT_W{1'b1}})) begin
            r_fail_count <= r_fail_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    fail_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fail_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .push  (w_qual),
        .pop   (w_pop_req),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rd_valid   = !w_empty;
    assign rd_entry   = w_head;
    assign fail_count = r_fail_count;
    assign overflow   = r_overflow;
    assign logging    = r_logging;

endmodule

// File: tb/tb_bist_fail_log.sv
// Bench for bist_fail_log: directed and random steps checked against a
// queue-based model of the fail log; a second instance uses a 3-bit counter.
module tb_bist_fail_log;
    import bist_pkg::*;

    localparam int TB_DEPTH = 4;
    localparam int EW       = PAT_W + SIZE + 2*LENGTH;

    logic              clk;
    logic              rst;
    logic              NbarT;
    logic              fail;
    logic [PAT_W-1:0]  pattern;
    logic [SIZE-1:0]   addr;
    logic [LENGTH-1:0] expected;
    logic [LENGTH-1:0] actual;
    logic              rdReady;

    logic              rdValid;
    logic [EW-1:0]     rdEntry;
    logic [7:0]        failCount;
    logic              overflowOut;
    logic              loggingOut;

    logic              satValid;
    logic [EW-1:0]     satEntry;
    logic [2:0]        satCount;
    logic              satOverflow;
    logic              satLogging;

    int checks = 0;
    int errors = 0;

    fail_entry_t modelQ[$];
    int          modelCount;
    logic        modelOverflow;
    logic        modelActive;

    bist_fail_log #(.SIZE(SIZE), .LENGTH(LENGTH), .DEPTH(TB_DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .NbarT(NbarT), .fail(fail), .pattern(pattern),
        .addr(addr), .expected(expected), .actual(actual), .rd_ready(rdReady),
        .rd_valid(rdValid), .rd_entry(rdEntry), .fail_count(failCount),
        .overflow(overflowOut), .logging(loggingOut)
    );

    bist_fail_log #(.SIZE(SIZE), .LENGTH(LENGTH), .DEPTH(TB_DEPTH), .CNT_W(3)) dutSat (
        .clk(clk), .rst(rst), .NbarT(NbarT), .fail(fail), .pattern(pattern),
        .addr(addr), .expected(expected), .actual(actual), .rd_ready(rdReady),
        .rd_valid(satValid), .rd_entry(satEntry), .fail_count(satCount),
        .overflow(satOverflow), .logging(satLogging)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] required);
        checks++;
        assert (observed === required) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, required);
        end
    endtask

    // Model: the log restarts whenever NbarT is seen high after being low.
    task automatic updateModel(input logic rstV, input logic nbartV, input logic failV,
                               input logic readyV, input fail_entry_t entryV);
        logic doClear;
        if (!rstV) begin
            modelQ.delete();
            modelCount    = 0;
            modelOverflow = 1'b0;
            modelActive   = 1'b0;
        end else begin
            doClear = nbartV && !modelActive;
            if (doClear) begin
                modelQ.delete();
                modelCount    = 0;
                modelOverflow = 1'b0;
            end else if (readyV && modelQ.size() > 0) begin
                void'(modelQ.pop_front());
            end
            if (failV && nbartV) begin
                if (modelQ.size() < TB_DEPTH) modelQ.push_back(entryV);
                else modelOverflow = 1'b1;
                modelCount++;
            end
            modelActive = nbartV;
        end
    endtask

    task automatic checkOutput(input string tag);
        fail_entry_t headExp;
        int sat8;
        int sat3;
        headExp = (modelQ.size() > 0) ? modelQ[0] : '0;
        sat8 = (modelCount > 255) ? 255 : modelCount;
        sat3 = (modelCount > 7) ? 7 : modelCount;
        check({tag, ".rd_valid"},   32'(rdValid),     32'(modelQ.size() > 0));
        check({tag, ".rd_entry"},   32'(rdEntry),     32'(headExp));
        check({tag, ".fail_count"}, 32'(failCount),   32'(sat8));
        check({tag, ".sat_count"},  32'(satCount),    32'(sat3));
        check({tag, ".overflow"},   32'(overflowOut), 32'(modelOverflow));
        check({tag, ".logging"},    32'(loggingOut),  32'(modelActive));
        check({tag, ".sat_entry"},  32'(satEntry),    32'(headExp));
    endtask

    task automatic applyStimulus(input string tag, input logic rstV, input logic nbartV,
                                 input logic failV, input logic readyV, input fail_entry_t entryV);
        rst     = rstV;
        NbarT   = nbartV;
        fail    = failV;
        rdReady = readyV;
        {pattern, addr, expected, actual} = entryV;
        @(posedge clk);
        updateModel(rstV, nbartV, failV, readyV, entryV);
        @(negedge clk);
        checkOutput(tag);
    endtask

    function automatic fail_entry_t randEntry();
        return fail_entry_t'($urandom());
    endfunction

    initial begin
        fail_entry_t e;
        modelCount    = 0;
        modelOverflow = 1'b0;
        modelActive   = 1'b0;
        rst = 1'b0; NbarT = 1'b1; fail = 1'b1; rdReady = 1'b0;
        {pattern, addr, expected, actual} = '0;

        applyStimulus("reset0", 1'b0, 1'b1, 1'b1, 1'b0, randEntry());
        applyStimulus("reset1", 1'b0, 1'b1, 1'b1, 1'b1, randEntry());

        for (int i = 0; i < 3; i++) applyStimulus("start", 1'b1, 1'b1, 1'b0, 1'b0, randEntry());
        e.pattern = 3'd2; e.addr = 6'h15; e.expected = 8'hAA; e.actual = 8'hAB;
        applyStimulus("single", 1'b1, 1'b1, 1'b1, 1'b0, e);
        check("single.literal", 32'(rdEntry), 32'({3'd2, 6'h15, 8'hAA, 8'hAB}));
        applyStimulus("single_pop", 1'b1, 1'b1, 1'b0, 1'b1, randEntry());

        for (int i = 0; i < 6; i++) applyStimulus("overflow", 1'b1, 1'b1, 1'b1, 1'b0, randEntry());
        for (int i = 0; i < 5; i++) applyStimulus("ovf_drain", 1'b1, 1'b1, 1'b0, 1'b1, randEntry());

        applyStimulus("reclear_low", 1'b1, 1'b0, 1'b0, 1'b0, randEntry());
        applyStimulus("reclear_high", 1'b1, 1'b1, 1'b0, 1'b0, randEntry());
        for (int i = 0; i < 4; i++) applyStimulus("fill", 1'b1, 1'b1, 1'b1, 1'b0, randEntry());
        applyStimulus("full_pushpop", 1'b1, 1'b1, 1'b1, 1'b1, randEntry());
        check("full_pushpop.no_overflow", 32'(overflowOut), 32'(0));
        for (int i = 0; i < 5; i++) applyStimulus("fp_drain", 1'b1, 1'b1, 1'b0, 1'b1, randEntry());

        for (int i = 0; i < 10; i++) applyStimulus("saturate", 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), randEntry());
        check("saturate.sat3", 32'(satCount), 32'(7));
        for (int i = 0; i < 260; i++) applyStimulus("saturate8", 1'b1, 1'b1, 1'b1, 1'b1, randEntry());

        applyStimulus("hold_low", 1'b1, 1'b0, 1'b0, 1'b0, randEntry());
        applyStimulus("hold_clear", 1'b1, 1'b1, 1'b1, 1'b0, randEntry());
        applyStimulus("hold_fill", 1'b1, 1'b1, 1'b1, 1'b0, randEntry());
        for (int i = 0; i < 3; i++) applyStimulus("hold_ignore", 1'b1, 1'b0, 1'b1, 1'b0, randEntry());
        applyStimulus("hold_pop", 1'b1, 1'b0, 1'b1, 1'b1, randEntry());
        applyStimulus("hold_reraise", 1'b1, 1'b1, 1'b0, 1'b0, randEntry());

        for (int i = 0; i < 400; i++) begin
            logic r, n;
            r = ($urandom_range(0, 49) != 0);
            n = ($urandom_range(0, 7) == 0) ? !NbarT : NbarT;
            applyStimulus("random", r, n, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), randEntry());
        end

        applyStimulus("final_reset", 1'b0, 1'b1, 1'b1, 1'b1, randEntry());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_fail_log.md
# bist_fail_log

Diagnostic capture stage downstream of the MBIST top. It consumes the per-cycle `fail` strobe together with the BIST pattern index, address, expected data and RAM read data. On each failing compare it stores one entry in a small FIFO, keeps a saturating fail counter and a sticky overflow flag, and drains entries to a host through a valid/ready read port. Drain is allowed during BIST or after it.

## Interface
Parameters:
- `SIZE`, 6, RAM address width (matches MBIST address mux)
- `LENGTH`, 8, RAM data width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CNT_W`, 8, fail counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `NbarT`  in  1  BIST mode from controller; 1 = test active
- `fail`  in  1  mismatch strobe from BIST top, valid in the same cycle as the capture fields
- `pattern`  in  3  BIST pattern index (counter bits [9:7])
- `addr`  in  SIZE  BIST address (counter bits [5:0])
- `expected`  in  LENGTH  decoder background data
- `actual`  in  LENGTH  RAM read data
- `rd_ready`  in  1  host accepts head entry
- `rd_valid`  out  1  FIFO non-empty
- `rd_entry`  out  3+2*LENGTH+SIZE  head entry, packed {pattern, addr, expected, actual}, MSB first
- `fail_count`  out  CNT_W  failures seen since last clear, saturating
- `overflow`  out  1  sticky; at least one failure was dropped because the FIFO was full
- `logging`  out  1  FSM is in LOGGING

## Operation
- FSM states and transitions:
  - IDLE → LOGGING when `NbarT`=1.
  - LOGGING → HOLD when `NbarT`=0.
  - HOLD → LOGGING when `NbarT`=1.
  - `logging` = (state==LOGGING).
- Clear: the IDLE→LOGGING and HOLD→LOGGING transition cycles (rising edge of `NbarT`) clear the FIFO, `fail_count` and `overflow`.
- Capture: push when `fail`=1, `NbarT`=1 and the FIFO is not full. `fail` while `NbarT`=0 is ignored.
- Clear and capture in the same cycle: clear is applied first, then the capture. Result: FIFO holds 1 entry, `fail_count`=1.
- Full FIFO with `fail`, no pop in that cycle: entry is dropped and `overflow` is set to 1.
- Full FIFO with `fail` and a pop in the same cycle: push is accepted, no overflow.
- `fail_count` increments on every qualified `fail`, including dropped ones. It saturates at 2^CNT_W−1 and does not wrap.
- Readout: show-ahead FIFO. `rd_entry` always reflects the head. A pop occurs on `rd_valid && rd_ready`. `rd_ready` while empty has no effect.
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged and both pointers advance (wrap modulo DEPTH).
- HOLD: the log is frozen except for pops. Contents persist until the next clear or reset.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; `rd_valid`=0, `rd_entry`=0, `fail_count`=0, `overflow`=0, `logging`=0. Reset overrides all other activity, including a reset asserted mid-test or mid-drain.
- Capture latency: a `fail` sampled at edge N gives `rd_valid`=1 (if previously empty) and an updated `fail_count` after edge N.
- Pop latency: the pop at edge N presents the next head (or `rd_valid`=0) after edge N.
- `logging` rises one cycle after `NbarT` rises and falls one cycle after `NbarT` falls.
- Capture inputs are not registered before use. They must be stable around the edge at which `fail` is high.

## Structure
- `bist_pkg`:
  - `localparam PAT_W = 3`
  - state enum `log_state_e` {IDLE, LOGGING, HOLD}
  - packed struct `fail_entry_t` {pattern, addr, expected, actual}, parameterised through package localparams `SIZE`/`LENGTH` defaults
- Sub-module `fail_fifo` (params `WIDTH`, `DEPTH`): synchronous show-ahead FIFO with `push`, `pop`, `clear`, `full`, `empty`, `head`.
  - Uses pointers one bit wider than log2(DEPTH).
- Top-level `bist_fail_log` holds the FSM, the counter, the overflow flag and the qualification logic.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `fail`=1 and `NbarT`=1 → all outputs 0, state IDLE.
- Single fail: raise `NbarT`; after 3 cycles pulse `fail` with pattern=2, addr=0x15, expected=0xAA, actual=0xAB → next cycle `rd_valid`=1, `rd_entry`={3'd2, 6'h15, 8'hAA, 8'hAB}, `fail_count`=1. Assert `rd_ready` 1 cycle → `rd_valid`=0.
- Overflow: with `rd_ready`=0, 6 consecutive fails (DEPTH=4) → 4 entries held, in order, from the first 4 fails; `overflow`=1; `fail_count`=6.
- Full + simultaneous pop/push: FIFO full, `fail`=1 and `rd_ready`=1 in the same cycle → `overflow` stays 0, occupancy stays 4, oldest entry removed, newest entry at the tail.
- Saturation: CNT_W=3, 10 fails → `fail_count`=7.
- Clear/hold: fill 2 entries, drop `NbarT` → `logging`=0, entries remain readable, `fail` is ignored. Re-raise `NbarT` → FIFO empty, counter 0, `overflow` 0.
